// File: rtl/bo_bing_scoring_if.sv
// Bo Bing scoring bus: six die faces in, one-hot prize vector out.
//   D1..D6  : 3-bit die faces, valid codes 1..6 (driven by the dice source)
//   P1..P6  : registered prize flags, P1 = highest prize (driven by the scorer)
//   invalid : registered invalid-roll flag, present only with BOBING_INVALID_OUT_EN
// Modports:
//   master : dice source side (drives D, observes P)
//   slave  : scorer side (observes D, drives P)
interface bo_bing_scoring_if;
  logic [2:0] D1;
  logic [2:0] D2;
  logic [2:0] D3;
  logic [2:0] D4;
  logic [2:0] D5;
  logic [2:0] D6;
  logic       P1;
  logic       P2;
  logic       P3;
  logic       P4;
  logic       P5;
  logic       P6;
`ifdef BOBING_INVALID_OUT_EN
  logic       invalid;
`endif

  modport master (
    output D1, D2, D3, D4, D5, D6,
`ifdef BOBING_INVALID_OUT_EN
    input  invalid,
`endif
    input  P1, P2, P3, P4, P5, P6
  );

  modport slave (
    input  D1, D2, D3, D4, D5, D6,
`ifdef BOBING_INVALID_OUT_EN
    output invalid,
`endif
    output P1, P2, P3, P4, P5, P6
  );
endinterface

// File: rtl/bo_bing_scoring.sv
// Bo Bing six-dice scoring block.
// Classifies six die faces combinationally and registers a one-hot (or all-zero)
// prize vector {P1..P6}, P1 = Zhuangyuan (highest) down to P6 = Yi Xiu.
// Latency is one clock: dice sampled at edge N appear on P after edge N.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, clears the prize register
//   bus : bo_bing_scoring_if.slave (D1..D6 in, P1..P6 out, optional invalid out)
// Optional feature macro: BOBING_INVALID_OUT_EN adds the registered 'invalid'
// output that flags rolls containing a face code of 0 or 7.
module bo_bing_scoring (
  input  logic                clk,
  input  logic                rst,
  bo_bing_scoring_if.slave    bus
);

  // Prize vector bit positions, P1 is the MSB.
  localparam int unsigned PrizeW = 6;
  localparam logic [PrizeW-1:0] PrizeP1   = 6'b100000;
  localparam logic [PrizeW-1:0] PrizeP2   = 6'b010000;
  localparam logic [PrizeW-1:0] PrizeP3   = 6'b001000;
  localparam logic [PrizeW-1:0] PrizeP4   = 6'b000100;
  localparam logic [PrizeW-1:0] PrizeP5   = 6'b000010;
  localparam logic [PrizeW-1:0] PrizeP6   = 6'b000001;
  localparam logic [PrizeW-1:0] PrizeNone = 6'b000000;

  // ---------------------------------------------------------------------------
  // Input gathering
  // ---------------------------------------------------------------------------
  logic [2:0] w_die [6];

  assign w_die[0] = bus.D1;
  assign w_die[1] = bus.D2;
  assign w_die[2] = bus.D3;
  assign w_die[3] = bus.D4;
  assign w_die[4] = bus.D5;
  assign w_die[5] = bus.D6;

  // ---------------------------------------------------------------------------
  // Face histogram: w_cnt[f] = number of dice showing face f (0..6)
  // ---------------------------------------------------------------------------
  logic [2:0] w_cnt [1:6];

  always_comb begin
    for (int f = 1; f <= 6; f++) begin
      w_cnt[f] = 3'd0;
      for (int i = 0; i < 6; i++) begin
        if (w_die[i] == 3'(f)) begin
          w_cnt[f] = w_cnt[f] + 3'd1;
        end
      end
    end
  end

  // Codes 0 and 7 are not die faces; such a roll never scores.
  logic w_invalid;

  always_comb begin
    w_invalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ((w_die[i] == 3'd0) || (w_die[i] == 3'd7)) begin
        w_invalid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern features derived from the histogram
  // ---------------------------------------------------------------------------
  logic [2:0] w_c4;          // count of fours
  logic       w_any_ge5;     // some face appears five or six times
  logic       w_straight;    // every face exactly once
  logic [2:0] w_num_triples; // faces with exactly three dice
  logic       w_quad_other;  // a non-four face appears exactly four times

  assign w_c4 = w_cnt[4];

  always_comb begin
    w_any_ge5     = 1'b0;
    w_straight    = 1'b1;
    w_num_triples = 3'd0;
    w_quad_other  = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      if (w_cnt[f] >= 3'd5) begin
        w_any_ge5 = 1'b1;
      end
      if (w_cnt[f] != 3'd1) begin
        w_straight = 1'b0;
      end
      if (w_cnt[f] == 3'd3) begin
        w_num_triples = w_num_triples + 3'd1;
      end
      if ((f != 4) && (w_cnt[f] == 3'd4)) begin
        w_quad_other = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priority classification, highest prize wins
  // ---------------------------------------------------------------------------
  logic [PrizeW-1:0] w_prize;

  always_comb begin
    w_prize = PrizeNone;
    if (!w_invalid) begin
      if ((w_c4 == 3'd4) || w_any_ge5) begin
        w_prize = PrizeP1;
      end else if (w_straight || (w_num_triples == 3'd2)) begin
        // Two triples covers the "three fours plus three of a kind" case,
        // so it must be checked before the plain three-fours rule.
        w_prize = PrizeP2;
      end else if (w_c4 == 3'd3) begin
        w_prize = PrizeP3;
      end else if (w_quad_other) begin
        // Four of a non-four face outranks any pair of fours alongside it.
        w_prize = PrizeP4;
      end else if (w_c4 == 3'd2) begin
        w_prize = PrizeP5;
      end else if (w_c4 == 3'd1) begin
        w_prize = PrizeP6;
      end else begin
        w_prize = PrizeNone;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  logic [PrizeW-1:0] r_prize;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prize <= PrizeNone;
    end else begin
      r_prize <= w_prize;
    end
  end

  assign bus.P1 = r_prize[5];
  assign bus.P2 = r_prize[4];
  assign bus.P3 = r_prize[3];
  assign bus.P4 = r_prize[2];
  assign bus.P5 = r_prize[1];
  assign bus.P6 = r_prize[0];

`ifdef BOBING_INVALID_OUT_EN
  logic r_invalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= w_invalid;
    end
  end

  assign bus.invalid = r_invalid;
`endif

endmodule

// File: tb/tb_bo_bing_scoring.sv
// Self-checking bench for bo_bing_scoring: directed rolls with literal expected
// prizes, plus a per-cycle comparison against a reference scoring model.
module tb_bo_bing_scoring;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bo_bing_scoring_if bus ();

  bo_bing_scoring u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [5:0] dut_p();
    return {bus.P1, bus.P2, bus.P3, bus.P4, bus.P5, bus.P6};
  endfunction

  // Reference model: scores a roll straight from the game rules.
  function automatic logic [5:0] model(input logic [2:0] a, b, c, d, e, f);
    int dice [6];
    int cnt [7];
    int triples;
    bit straight;
    bit quad_other;
    int maxc;
    dice = '{int'(a), int'(b), int'(c), int'(d), int'(e), int'(f)};
    foreach (cnt[k]) cnt[k] = 0;
    foreach (dice[k]) begin
      if (dice[k] < 1 || dice[k] > 6) return 6'b000000;
      cnt[dice[k]]++;
    end
    triples = 0; straight = 1; quad_other = 0; maxc = 0;
    for (int k = 1; k <= 6; k++) begin
      if (cnt[k] > maxc) maxc = cnt[k];
      if (cnt[k] == 3) triples++;
      if (cnt[k] != 1) straight = 0;
      if (k != 4 && cnt[k] == 4) quad_other = 1;
    end
    if (cnt[4] == 4 || maxc >= 5) return 6'b100000;
    if (straight || triples == 2) return 6'b010000;
    if (cnt[4] == 3)              return 6'b001000;
    if (quad_other)               return 6'b000100;
    if (cnt[4] == 2)              return 6'b000010;
    if (cnt[4] == 1)              return 6'b000001;
    return 6'b000000;
  endfunction

  function automatic bit model_invalid(input logic [2:0] a, b, c, d, e, f);
    logic [2:0] v [6];
    v = '{a, b, c, d, e, f};
    foreach (v[k]) if (v[k] == 3'd0 || v[k] == 3'd7) return 1'b1;
    return 1'b0;
  endfunction

  // Scoreboard: what the output register must hold after each edge.
  logic [5:0] exp_p     = 6'b000000;
  logic       exp_inv   = 1'b0;
  logic       exp_valid = 1'b0;

  always @(posedge clk) begin
    exp_p     <= rst ? 6'b000000 : model(bus.D1, bus.D2, bus.D3, bus.D4, bus.D5, bus.D6);
    exp_inv   <= rst ? 1'b0 : model_invalid(bus.D1, bus.D2, bus.D3, bus.D4, bus.D5, bus.D6);
    exp_valid <= 1'b1;
  end

  // Mid-cycle compare: also catches any output change away from the clock edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("pipe_model", dut_p(), exp_p);
`ifdef BOBING_INVALID_OUT_EN
      check("pipe_invalid", {5'b0, bus.invalid}, {5'b0, exp_inv});
`endif
    end
  end

  task automatic set_dice(input logic [2:0] a, b, c, d, e, f);
    bus.D1 = a; bus.D2 = b; bus.D3 = c; bus.D4 = d; bus.D5 = e; bus.D6 = f;
  endtask

  // One roll per cycle; inputs change on the falling edge, result checked
  // just after the following rising edge.
  task automatic roll(input string name, input logic [2:0] a, b, c, d, e, f,
                      input logic [5:0] exp_lit);
    @(negedge clk);
    set_dice(a, b, c, d, e, f);
    check({name, "_model"}, model(a, b, c, d, e, f), exp_lit);
    @(posedge clk);
    #1;
    check(name, dut_p(), exp_lit);
  endtask

  initial begin
    set_dice(3'd4, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2);
    rst = 1'b1;

    // Reset held for two edges with a P1 roll on the inputs.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", dut_p(), 6'b000000);
`ifdef BOBING_INVALID_OUT_EN
      check("reset_invalid", {5'b0, bus.invalid}, 6'b000000);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", dut_p(), 6'b100000);

    // Invalid rolls.
    roll("inv_7_0", 3'd7, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 6'b000000);
`ifdef BOBING_INVALID_OUT_EN
    check("inv_flag_a", {5'b0, bus.invalid}, 6'b000001);
`endif
    roll("inv_0", 3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 6'b000000);
`ifdef BOBING_INVALID_OUT_EN
    check("inv_flag_b", {5'b0, bus.invalid}, 6'b000001);
`endif

    // P1 / P2.
    roll("p1_four4", 3'd4, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2, 6'b100000);
    roll("p1_five1", 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 6'b100000);
    roll("p1_five6", 3'd2, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 6'b100000);
    roll("p1_six4",  3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 6'b100000);
    roll("p1_five4", 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 6'b100000);
    roll("p2_strt",  3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 6'b010000);
    roll("p2_1_2",   3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 6'b010000);
    roll("p2_4_3",   3'd4, 3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 6'b010000);

    // P3 / P4.
    roll("p3_three4", 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 6'b001000);
    roll("p4_1111",   3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 6'b000100);
    roll("p4_5555",   3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 6'b000100);
    roll("p4_6666",   3'd6, 3'd6, 3'd6, 3'd6, 3'd1, 3'd1, 6'b000100);
    roll("p4_over_p5", 3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 6'b000100);
    roll("p4_3333_44", 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 6'b000100);

    // P5 / P6 / none.
    roll("p5_two4",  3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4, 6'b000010);
    roll("p6_one4",  3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd4, 6'b000001);
    roll("none",     3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd6, 6'b000000);
    roll("p3_after_none", 3'd4, 3'd4, 3'd4, 3'd1, 3'd2, 3'd2, 6'b001000);

    // Reset mid-stream discards the roll sampled on the same edge.
    @(negedge clk);
    set_dice(3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", dut_p(), 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    roll("after_reset", 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 6'b100000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
